// File: rtl/csr_regfile_pkg.sv
// -----------------------------------------------------------------------------
// csr_regfile_pkg
// Shared definitions for the machine-mode CSR file:
//   - CSR address constants
//   - mstatus / mie / mip bit positions
//   - interrupt cause codes
//   - writable-bit masks
//   - priority encoder that selects the interrupt to report
// -----------------------------------------------------------------------------
package csr_regfile_pkg;

    // CSR address map
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    // mstatus fields
    localparam int MSTATUS_MIE_BIT    = 3;
    localparam int MSTATUS_MPIE_BIT   = 7;
    localparam int MSTATUS_MPP_LO_BIT = 11;
    localparam int MSTATUS_MPP_HI_BIT = 12;

    // mie / mip bit positions (same layout for both registers)
    localparam int IRQ_MSI_BIT = 3;
    localparam int IRQ_MTI_BIT = 7;
    localparam int IRQ_MEI_BIT = 11;

    // Interrupt cause codes
    localparam logic [3:0] INT_CODE_NONE = 4'd0;
    localparam logic [3:0] INT_CODE_MSI  = 4'd3;
    localparam logic [3:0] INT_CODE_MTI  = 4'd7;
    localparam logic [3:0] INT_CODE_MEI  = 4'd11;

    // Writable bits of the low 12 bits of mie (everything above is hardwired 0)
    localparam logic [11:0] MIE_WMASK = 12'h888;

    // Highest-priority pending interrupt: external > software > timer
    function automatic logic [3:0] irq_code_f(input logic [11:0] pend);
        logic [3:0] code;
        if (pend[IRQ_MEI_BIT]) begin
            code = INT_CODE_MEI;
        end else if (pend[IRQ_MSI_BIT]) begin
            code = INT_CODE_MSI;
        end else if (pend[IRQ_MTI_BIT]) begin
            code = INT_CODE_MTI;
        end else begin
            code = INT_CODE_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/csr_regfile_counter.sv
// -----------------------------------------------------------------------------
// csr_counter
// Free-running counter with a load port. A load in the same cycle as an
// increment wins: the counter takes load_data and does not increment.
// Wraps from all-ones to zero.
// Ports:
//   clk, rst    clock, asynchronous active-high reset (count -> 0)
//   inc_en      add one this cycle
//   load_en     load load_data this cycle (priority over inc_en)
//   load_data   value to load
//   count       current counter value (registered)
// -----------------------------------------------------------------------------
module csr_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Counter state: load has priority over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load_en) begin
            count_r <= load_data;
        end else if (inc_en) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_r;

endmodule

// File: rtl/csr_regfile.sv
// -----------------------------------------------------------------------------
// csr_regfile
// Machine-mode CSR storage for the 64-bit in-order pipeline.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   csr_ridx_i            read index; csr_rdata_o / csr_ilegl_o are combinational
//   csr_wen_i/widx/wdata  software CSR write from writeback
//   trap_i, mret_i        trap entry / mret retiring in writeback
//   mcause/mtval/mepc_*   trap-side register updates (ignored during mret)
//   instret_i             one instruction retired (minstret increment)
//   *_irq_i               level interrupt sources, form mip
//   mtvec_rdata_o         trap vector, pre-update value for redirect
//   mepc_rdata_o          return PC, pre-update value for redirect
//   int_pending_o         an enabled interrupt is pending and MIE is set
//   int_code_o            cause code of the interrupt to take (0 when none)
// When trap_i and mret_i are both high, mret takes precedence.
// -----------------------------------------------------------------------------
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] MTVEC_RST = {XLEN{1'b0}},
    parameter logic [XLEN-1:0] MISA_VAL  = 64'h8000_0000_0000_0100,
    parameter int              HART_ID   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_ridx_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_ilegl_o,
    input  logic            csr_wen_i,
    input  logic [11:0]     csr_widx_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    input  logic            trap_i,
    input  logic            mret_i,
    input  logic            mcause_wen_i,
    input  logic [XLEN-1:0] mcause_wdata_i,
    input  logic            mtval_wen_i,
    input  logic [XLEN-1:0] mtval_wdata_i,
    input  logic            mepc_wen_i,
    input  logic [XLEN-1:0] mepc_wdata_i,
    input  logic            instret_i,
    input  logic            timer_irq_i,
    input  logic            sw_irq_i,
    input  logic            ext_irq_i,
    output logic [XLEN-1:0] mtvec_rdata_o,
    output logic [XLEN-1:0] mepc_rdata_o,
    output logic            int_pending_o,
    output logic [3:0]      int_code_o
);

    // Clears bits [1:0] for 4-byte aligned addresses
    localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

    logic            mie_bit_r;
    logic            mpie_bit_r;
    logic [11:0]     mie_r;
    logic [XLEN-1:0] mtvec_r;
    logic [XLEN-1:0] mscratch_r;
    logic [XLEN-1:0] mepc_r;
    logic [XLEN-1:0] mcause_r;
    logic [XLEN-1:0] mtval_r;
    logic [XLEN-1:0] mcycle_s;
    logic [XLEN-1:0] minstret_s;

    logic            trap_take_s;
    logic            we_mstatus_s;
    logic            we_mie_s;
    logic            we_mtvec_s;
    logic            we_mscratch_s;
    logic            we_mepc_s;
    logic            we_mcause_s;
    logic            we_mtval_s;
    logic            we_mcycle_s;
    logic            we_minstret_s;

    logic [XLEN-1:0] mstatus_s;
    logic [11:0]     mip_s;
    logic [11:0]     pend_s;
    logic [XLEN-1:0] rdata_s;
    logic            ilegl_s;

    // A trap only acts when no mret is retiring in the same cycle
    assign trap_take_s = trap_i & ~mret_i;

    // Software write decode
    always_comb begin
        we_mstatus_s  = csr_wen_i & (csr_widx_i == CSR_MSTATUS);
        we_mie_s      = csr_wen_i & (csr_widx_i == CSR_MIE);
        we_mtvec_s    = csr_wen_i & (csr_widx_i == CSR_MTVEC);
        we_mscratch_s = csr_wen_i & (csr_widx_i == CSR_MSCRATCH);
        we_mepc_s     = csr_wen_i & (csr_widx_i == CSR_MEPC);
        we_mcause_s   = csr_wen_i & (csr_widx_i == CSR_MCAUSE);
        we_mtval_s    = csr_wen_i & (csr_widx_i == CSR_MTVAL);
        we_mcycle_s   = csr_wen_i & (csr_widx_i == CSR_MCYCLE);
        we_minstret_s = csr_wen_i & (csr_widx_i == CSR_MINSTRET);
    end

    // mstatus interrupt-enable stack: mret > trap > software write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_bit_r  <= 1'b0;
            mpie_bit_r <= 1'b0;
        end else if (mret_i) begin
            mie_bit_r  <= mpie_bit_r;
            mpie_bit_r <= 1'b1;
        end else if (trap_take_s) begin
            mpie_bit_r <= mie_bit_r;
            mie_bit_r  <= 1'b0;
        end else if (we_mstatus_s) begin
            mie_bit_r  <= csr_wdata_i[MSTATUS_MIE_BIT];
            mpie_bit_r <= csr_wdata_i[MSTATUS_MPIE_BIT];
        end
    end

    // Software-only registers: mie, mtvec, mscratch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_r      <= 12'h000;
            mtvec_r    <= MTVEC_RST & ALIGN_MASK;
            mscratch_r <= {XLEN{1'b0}};
        end else begin
            if (we_mie_s) begin
                mie_r <= csr_wdata_i[11:0] & MIE_WMASK;
            end
            if (we_mtvec_s) begin
                mtvec_r <= csr_wdata_i & ALIGN_MASK;
            end
            if (we_mscratch_s) begin
                mscratch_r <= csr_wdata_i;
            end
        end
    end

    // Trap-side registers: a trap write beats a software write to the same CSR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mepc_r   <= {XLEN{1'b0}};
            mcause_r <= {XLEN{1'b0}};
            mtval_r  <= {XLEN{1'b0}};
        end else begin
            if (trap_take_s && mepc_wen_i) begin
                mepc_r <= mepc_wdata_i & ALIGN_MASK;
            end else if (we_mepc_s) begin
                mepc_r <= csr_wdata_i & ALIGN_MASK;
            end
            if (trap_take_s && mcause_wen_i) begin
                mcause_r <= mcause_wdata_i;
            end else if (we_mcause_s) begin
                mcause_r <= csr_wdata_i;
            end
            if (trap_take_s && mtval_wen_i) begin
                mtval_r <= mtval_wdata_i;
            end else if (we_mtval_s) begin
                mtval_r <= csr_wdata_i;
            end
        end
    end

    csr_counter #(.WIDTH(XLEN)) u_mcycle (
        .clk       (clk),
        .rst       (rst),
        .inc_en    (1'b1),
        .load_en   (we_mcycle_s),
        .load_data (csr_wdata_i),
        .count     (mcycle_s)
    );

    csr_counter #(.WIDTH(XLEN)) u_minstret (
        .clk       (clk),
        .rst       (rst),
        .inc_en    (instret_i),
        .load_en   (we_minstret_s),
        .load_data (csr_wdata_i),
        .count     (minstret_s)
    );

    // Architectural mstatus view: MPP hardwired to M-mode, other fields zero
    always_comb begin
        mstatus_s                                       = {XLEN{1'b0}};
        mstatus_s[MSTATUS_MPP_HI_BIT:MSTATUS_MPP_LO_BIT] = 2'b11;
        mstatus_s[MSTATUS_MPIE_BIT]                     = mpie_bit_r;
        mstatus_s[MSTATUS_MIE_BIT]                      = mie_bit_r;
    end

    // mip mirrors the live interrupt lines
    always_comb begin
        mip_s              = 12'h000;
        mip_s[IRQ_MSI_BIT] = sw_irq_i;
        mip_s[IRQ_MTI_BIT] = timer_irq_i;
        mip_s[IRQ_MEI_BIT] = ext_irq_i;
    end

    assign pend_s = mie_r & mip_s;

    // Interrupt report is gated by the global MIE so code is 0 whenever not pending
    always_comb begin
        int_pending_o = mie_bit_r & (|pend_s);
        int_code_o    = mie_bit_r ? irq_code_f(pend_s) : INT_CODE_NONE;
    end

    // Combinational read mux; no write bypass
    always_comb begin
        rdata_s = {XLEN{1'b0}};
        ilegl_s = 1'b0;
        case (csr_ridx_i)
            CSR_MSTATUS:  rdata_s = mstatus_s;
            CSR_MISA:     rdata_s = MISA_VAL;
            CSR_MIE:      rdata_s = {{(XLEN-12){1'b0}}, mie_r};
            CSR_MTVEC:    rdata_s = mtvec_r;
            CSR_MSCRATCH: rdata_s = mscratch_r;
            CSR_MEPC:     rdata_s = mepc_r;
            CSR_MCAUSE:   rdata_s = mcause_r;
            CSR_MTVAL:    rdata_s = mtval_r;
            CSR_MIP:      rdata_s = {{(XLEN-12){1'b0}}, mip_s};
            CSR_MCYCLE:   rdata_s = mcycle_s;
            CSR_MINSTRET: rdata_s = minstret_s;
            CSR_MHARTID:  rdata_s = XLEN'(HART_ID);
            default:      ilegl_s = 1'b1;
        endcase
    end

    assign csr_rdata_o   = rdata_s;
    assign csr_ilegl_o   = ilegl_s;
    assign mtvec_rdata_o = mtvec_r;
    assign mepc_rdata_o  = mepc_r;

endmodule
